// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op/state encodings and helpers for the ALU and mul/div unit
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - applies operand signs to the magnitude result and selects the output word
module muldiv_sign_fix
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        op_i,
  input  logic              neg_a_i,
  input  logic              neg_b_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // acc holds {hi, lo} of the product, or {remainder, quotient} after a divide
  always_comb begin
    prod = (neg_a_i ^ neg_b_i) ? -acc_i : acc_i;
    quot = (neg_a_i ^ neg_b_i) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem  = neg_a_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
    case (op_i)
      MD_MUL:                      result_o = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result_o = quot;
      default:                     result_o = rem;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready handshake and flush
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEFAULT,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            is_zero_o
);

  md_state_e         state_q;
  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              is_zero_q, in_ready_q, out_valid_q;

  logic            neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, fix_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    neg_a    = op_a_signed(op_i) & a_i[XLEN-1];
    neg_b    = op_b_signed(op_i) & b_i[XLEN-1];
    a_mag    = neg_a ? -a_i : a_i;
    b_mag    = neg_b ? -b_i : b_i;
    div_zero = op_i[2] & (b_i == '0);
    div_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) &
               (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
    // op_i[1] separates REM/REMU from DIV/DIVU
    if (div_zero) fast_res = op_i[1] ? a_i : '1;
    else          fast_res = op_i[1] ? '0 : a_i;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (op_q[2]) begin
      acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i    (op_q),
    .neg_a_i (neg_a_q),
    .neg_b_i (neg_b_q),
    .acc_i   (acc_d),
    .result_o(fix_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= MD_MUL;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      b_mag_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      is_zero_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      is_zero_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            op_q       <= op_i;
            neg_a_q    <= neg_a;
            neg_b_q    <= neg_b;
            b_mag_q    <= b_mag;
            acc_q      <= {{XLEN{1'b0}}, a_mag};
            in_ready_q <= 1'b0;
            if (div_zero || div_ovf) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= fast_res;
              is_zero_q   <= (fast_res == '0);
            end else begin
              state_q <= S_CALC;
              cnt_q   <= CNT_W'(XLEN);
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= fix_res;
            is_zero_q   <= (fix_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign is_zero_o   = is_zero_q;

endmodule
